muntjac_fetch_queue: RTL

Decoupling FIFO between the instruction aligner and the decode stage. Each cycle it accepts up to two aligned instructions and presents one instruction per cycle to decode with a valid/ready handshake. Its depth absorbs fetch bubbles and decode stalls. On pipeline redirect it is flushed in a single cycle.

---
 rtl/muntjac_pkg.sv | 17 +
 rtl/muntjac_fetch_queue.sv | 114 +++++++++++
 2 files changed

// File: rtl/muntjac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muntjac_pkg
// Purpose  : Shared types for the Muntjac front end.
//            fetched_instr_t is one aligned instruction as produced by the
//            aligner and consumed by decode.
// Revision : 1.0 - initial release
// ============================================================================
package muntjac_pkg;

  typedef struct packed {
    logic [63:0] pc;          // address of the instruction
    logic [31:0] instr_word;  // raw instruction bits (compressed in [15:0])
  } fetched_instr_t;

endpackage : muntjac_pkg
`default_nettype wire

// File: rtl/muntjac_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : muntjac_fetch_queue
// Purpose  : Decoupling FIFO between the instruction aligner and decode.
//            Accepts up to two aligned instructions per cycle, presents one
//            per cycle to decode, and is emptied in one cycle on redirect.
// Ports    : clk_i        - clock
//            rst_ni       - asynchronous active-low reset
//            flush_i      - discard all contents (pipeline redirect)
//            in_valid_i   - per-lane valid, lane 0 older (00, 01 or 11 only)
//            in_instr_i   - aligned instructions from the aligner
//            in_ready_o   - queue can take two instructions this cycle
//            out_valid_o  - head entry is valid
//            out_ready_i  - decode consumes the head
//            out_instr_o  - head entry
//            count_o      - current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module muntjac_fetch_queue
  import muntjac_pkg::*;
#(
  parameter int unsigned Depth   = 4,  // power of two, at least 2
  parameter int unsigned InWidth = 2   // fixed at 2 in this revision
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic           [InWidth-1:0]  in_valid_i,
  input  fetched_instr_t [InWidth-1:0]  in_instr_i,
  output logic                          in_ready_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output fetched_instr_t                out_instr_o,
  output logic       [$clog2(Depth):0]  count_o
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CountW = $clog2(Depth) + 1;

  fetched_instr_t    r_mem [Depth];
  logic [PtrW-1:0]   r_rd_ptr;
  logic [PtrW-1:0]   r_wr_ptr;
  logic [CountW-1:0] r_count;

  logic              w_enq;
  logic              w_deq;
  logic [CountW-1:0] w_enq_n;
  logic [CountW-1:0] w_deq_n;
  logic [CountW-1:0] w_count_next;
  logic [PtrW-1:0]   w_wr_ptr_p1;

  // Ready looks only at the registered count, so decode backpressure never
  // reaches the aligner combinationally. Two free slots are always required
  // because the aligner may offer a full pair.
  assign in_ready_o  = (r_count <= CountW'(Depth - 2));
  assign out_valid_o = (r_count != '0);
  assign out_instr_o = r_mem[r_rd_ptr];
  assign count_o     = r_count;

  // Flush suppresses both handshakes in its cycle.
  assign w_enq = in_ready_o && (|in_valid_i) && !flush_i;
  assign w_deq = out_valid_o && out_ready_i && !flush_i;

  assign w_enq_n = w_enq ? (CountW'(in_valid_i[0]) + CountW'(in_valid_i[1])) : '0;
  assign w_deq_n = CountW'(w_deq);
  assign w_count_next = r_count + w_enq_n - w_deq_n;

  // Pointers are exactly log2(Depth) wide, so natural overflow is the
  // modulo-Depth wrap (lane 1 lands at index 0 when wr_ptr is Depth-1).
  assign w_wr_ptr_p1 = r_wr_ptr + PtrW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      // Storage is left as is; an empty queue never exposes it as valid.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_mem[r_wr_ptr] <= in_instr_i[0];
        if (in_valid_i[1]) begin
          r_mem[w_wr_ptr_p1] <= in_instr_i[1];
        end
        r_wr_ptr <= r_wr_ptr + w_enq_n[PtrW-1:0];
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= w_count_next;
    end
  end

  // --------------------------------------------------------------------------
  // Protocol and invariant checks
  // --------------------------------------------------------------------------
  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_count <= CountW'(Depth));

  a_enq_needs_ready : assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_enq |-> in_ready_o);

  // Lane 1 may only be valid together with the older lane 0.
  a_lane_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(in_valid_i[1] && !in_valid_i[0]));

endmodule : muntjac_fetch_queue
`default_nettype wire
